multi_signal_debouncer: RTL and testbench
=========================================

// Module: multi_signal_debouncer
//
// PURPOSE
// Multi-channel successor to the single-input debouncer: synchronises and debounces NUM_CHANNELS
// independent asynchronous inputs (buttons, DIP switches, mode straps) in the sys_clk domain.
// Each channel has its own input polarity, synchroniser and stability counter.
// Optional edge pulses feed control FSMs without extra edge-detect logic.
//
// PARAMETERS
// NUM_CHANNELS    4           number of independent channels (>=1)
// DEBOUNCE_COUNT  16          consecutive stable sys_clk cycles needed to accept a new level (>=1)
// SYNC_STAGES     2           input synchroniser flops per channel (>=2)
// IN_ACTIVE_LOW   {N{1'b1}}   per-channel mask; bit i=1 -> in_sig[i] is active-low
// OUT_ACTIVE_LOW  0           1 -> all out_sig bits active-low, 0 -> active-high
//
// PORTS
// sys_clk     in   1  system clock; all logic on rising edge
// rst         in   1  synchronous reset, active-high
// in_sig      in   N  raw asynchronous inputs, N = NUM_CHANNELS
// out_sig     out  N  debounced level per channel, polarity per OUT_ACTIVE_LOW
// rise_pulse  out  N  (DEBOUNCER_EDGE_PULSE_EN only) 1-cycle pulse, logical inactive->active
// fall_pulse  out  N  (DEBOUNCER_EDGE_PULSE_EN only) 1-cycle pulse, logical active->inactive
//
// BEHAVIOUR
// - Reset (rst=1 at a rising edge): sync flops <= inactive raw level (IN_ACTIVE_LOW[i]);
//   logical state st[i] <= 0; counters <= 0; out_sig = {N{OUT_ACTIVE_LOW}}; pulses <= 0.
// - Synchroniser: SYNC_STAGES-flop chain per channel; logical level lv[i] = sync_out[i] ^ IN_ACTIVE_LOW[i].
// - Counter cnt[i], width $clog2(DEBOUNCE_COUNT+1), one per channel, per cycle:
//   * lv[i]==st[i]: cnt[i] <= 0 (any bounce back restarts qualification).
//   * lv[i]!=st[i] and cnt[i] < DEBOUNCE_COUNT-1: cnt[i] <= cnt[i]+1.
//   * lv[i]!=st[i] and cnt[i]==DEBOUNCE_COUNT-1: st[i] <= lv[i], cnt[i] <= 0.
//   Counter never wraps; saturation unreachable by construction.
// - Latency: clean input step at edge k -> out_sig changes at edge k+SYNC_STAGES+DEBOUNCE_COUNT-1
//   (first visible after edge k+SYNC_STAGES+DEBOUNCE_COUNT-1, i.e. SYNC+COUNT edges incl. k).
//   Glitch of fewer than DEBOUNCE_COUNT synchronised cycles never reaches out_sig.
// - out_sig[i] = st[i] ^ OUT_ACTIVE_LOW, registered (no combinational path from in_sig).
// - Channels fully independent; simultaneous transitions on several channels handled in parallel.
// - Reset mid-qualification discards partial counts; full window required after rst falls.
// - Per-channel state per channel: IDLE_STABLE (cnt==0) -> QUALIFYING (lv!=st) ->
//   back to IDLE_STABLE on bounce (st kept) or on count expiry (st toggled).
//
// CONFIGURATION
// `DEBOUNCER_EDGE_PULSE_EN defined: rise_pulse/fall_pulse ports present; registered, high for
//   exactly the one cycle in which out_sig first shows the new level; never both high on a channel;
//   0 during and after reset (no pulse from reset release).
// Not defined: rise_pulse/fall_pulse ports and logic absent; out_sig behaviour identical.
//
// TESTING  (NUM_CHANNELS=4, DEBOUNCE_COUNT=16, SYNC_STAGES=2, IN_ACTIVE_LOW=4'hF, OUT_ACTIVE_LOW=0, 12 MHz)
// 1. rst=1 for 4 cycles, in_sig=4'hF -> out_sig=4'h0, rise/fall_pulse=4'h0; stays 4'h0 after rst=0.
// 2. in_sig[0] 1->0 cleanly, held -> out_sig[0]=1 exactly 18 edges later; rise_pulse[0]=1 for one
//    cycle, same cycle; other channels unchanged.
// 3. in_sig[1] toggled every 5 cycles for 100 cycles, then held 0 -> out_sig[1] stays 0 during
//    bounce; goes 1 exactly 18 edges after final settle.
// 4. in_sig[2] low for 15 cycles then high -> out_sig[2] never changes, no pulses; 16-cycle low -> accepted.
// 5. ch0 released (0->1) and ch3 pressed (1->0) on the same edge -> out_sig=4'b1000 after 18 edges;
//    fall_pulse[0] and rise_pulse[3] both high in that one cycle.
// 6. in_sig[2] low for 10 cycles, rst pulsed 1 cycle, input held low -> out_sig[2] goes 1 only
//    18 edges after rst falls (partial count discarded), not earlier.

Source files
------------

// File: rtl/multi_signal_debouncer.sv
// multi_signal_debouncer
//
// Purpose:
//   Synchronises and debounces NUM_CHANNELS independent asynchronous inputs
//   in the sys_clk domain. Each channel has its own input polarity,
//   synchroniser chain and stability counter. A new level is accepted only
//   after the synchronised input has differed from the accepted level for
//   DEBOUNCE_COUNT consecutive cycles. Any bounce back restarts qualification.
//
// Ports:
//   sys_clk     in   1  system clock, all logic on the rising edge
//   rst         in   1  synchronous reset, active-high
//   in_sig      in   N  raw asynchronous inputs (per-channel polarity IN_ACTIVE_LOW)
//   out_sig     out  N  registered debounced level (polarity OUT_ACTIVE_LOW)
//   rise_pulse  out  N  one-cycle pulse, logical inactive->active (optional)
//   fall_pulse  out  N  one-cycle pulse, logical active->inactive (optional)
//
// Configuration:
//   DEBOUNCER_EDGE_PULSE_EN  when defined, rise_pulse/fall_pulse ports and
//                            their registers are present. When undefined they
//                            are absent and out_sig behaves identically.

module multi_signal_debouncer #(
  parameter int                      NUM_CHANNELS   = 4,
  parameter int                      DEBOUNCE_COUNT = 16,
  parameter int                      SYNC_STAGES    = 2,
  parameter logic [NUM_CHANNELS-1:0] IN_ACTIVE_LOW  = {NUM_CHANNELS{1'b1}},
  parameter bit                      OUT_ACTIVE_LOW = 1'b0
) (
  input  logic                    sys_clk,
  input  logic                    rst,
  input  logic [NUM_CHANNELS-1:0] in_sig,
  output logic [NUM_CHANNELS-1:0] out_sig
`ifdef DEBOUNCER_EDGE_PULSE_EN
  ,
  output logic [NUM_CHANNELS-1:0] rise_pulse,
  output logic [NUM_CHANNELS-1:0] fall_pulse
`endif
);

  localparam int CW = $clog2(DEBOUNCE_COUNT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_COUNT - 1);

  // Per-channel qualification phase. IDLE_STABLE means the synchronised
  // level agrees with the accepted level; QUALIFYING means it differs and
  // the counter is measuring how long it has stayed that way.
  typedef enum logic {
    IDLE_STABLE = 1'b0,
    QUALIFYING  = 1'b1
  } phase_e;

  logic [NUM_CHANNELS-1:0] sync_q [SYNC_STAGES];
  logic [NUM_CHANNELS-1:0] lv;
  logic [NUM_CHANNELS-1:0] st_q;
  logic [NUM_CHANNELS-1:0] st_d;
  logic [CW-1:0]           cnt_q [NUM_CHANNELS];
  logic [CW-1:0]           cnt_d [NUM_CHANNELS];
  phase_e                  phase [NUM_CHANNELS];

`ifdef DEBOUNCER_EDGE_PULSE_EN
  logic [NUM_CHANNELS-1:0] rise_q;
  logic [NUM_CHANNELS-1:0] rise_d;
  logic [NUM_CHANNELS-1:0] fall_q;
  logic [NUM_CHANNELS-1:0] fall_d;
`endif

  // The XOR folds each channel's input polarity away, so everything
  // downstream works on logical levels where 1 means "active".
  assign lv = sync_q[SYNC_STAGES-1] ^ IN_ACTIVE_LOW;

  // Next-state logic. The accepted level toggles on the cycle the counter
  // has already seen DEBOUNCE_COUNT-1 differing cycles and the current one
  // still differs, so exactly DEBOUNCE_COUNT consecutive differing cycles
  // are required. The counter restarts on acceptance and on any bounce, so
  // it can never exceed DEBOUNCE_COUNT-1.
  always_comb begin
    st_d = st_q;
`ifdef DEBOUNCER_EDGE_PULSE_EN
    rise_d = '0;
    fall_d = '0;
`endif
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      cnt_d[i] = '0;
      phase[i] = IDLE_STABLE;
    end
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      phase[i] = (lv[i] != st_q[i]) ? QUALIFYING : IDLE_STABLE;
      unique case (phase[i])
        IDLE_STABLE: begin
          cnt_d[i] = '0;
        end
        QUALIFYING: begin
          if (cnt_q[i] == CNT_LAST) begin
            st_d[i]  = lv[i];
            cnt_d[i] = '0;
`ifdef DEBOUNCER_EDGE_PULSE_EN
            rise_d[i] = lv[i];
            fall_d[i] = ~lv[i];
`endif
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
        default: begin
          cnt_d[i] = '0;
        end
      endcase
    end
  end

  // State register. Reset loads the synchroniser with each channel's
  // inactive raw level so that releasing reset with idle inputs never
  // starts a qualification, and discards any partial count.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= IN_ACTIVE_LOW;
      end
      st_q <= '0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        cnt_q[i] <= '0;
      end
`ifdef DEBOUNCER_EDGE_PULSE_EN
      rise_q <= '0;
      fall_q <= '0;
`endif
    end else begin
      sync_q[0] <= in_sig;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
      st_q <= st_d;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
`ifdef DEBOUNCER_EDGE_PULSE_EN
      rise_q <= rise_d;
      fall_q <= fall_d;
`endif
    end
  end

  // Output polarity is a constant inversion of the registered state, so
  // there is no combinational path from in_sig to out_sig.
  assign out_sig = st_q ^ {NUM_CHANNELS{OUT_ACTIVE_LOW}};

`ifdef DEBOUNCER_EDGE_PULSE_EN
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
`endif

endmodule

// File: tb/tb_multi_signal_debouncer.sv
// tb_multi_signal_debouncer
//
// Purpose:
//   Self-checking bench for multi_signal_debouncer. The stimulus process
//   drives rst/in_sig once per cycle, steps a behavioural reference model and
//   pushes the expected post-edge outputs into a queue. A monitor pops one
//   entry after every rising edge and compares it with the DUT.
//   Directed scenarios (reset, clean press, bounce, short glitch, parallel
//   transitions, reset mid-qualification) are followed by random stimulus.
//
// Ports: none (top-level bench).
//
// Configuration:
//   DEBOUNCER_EDGE_PULSE_EN  when defined, the pulse outputs are connected and checked.

`timescale 1ns/1ps

module tb_multi_signal_debouncer;

  localparam int         NCH      = 4;
  localparam int         COUNT    = 16;
  localparam int         SYNC     = 2;
  localparam logic [3:0] IN_LOW   = 4'hF;
  localparam bit         OUT_LOW  = 1'b0;

  typedef struct packed {
    logic [NCH-1:0] outv;
    logic [NCH-1:0] rise;
    logic [NCH-1:0] fall;
  } exp_t;

  logic           sys_clk = 1'b0;
  logic           rst     = 1'b1;
  logic [NCH-1:0] in_sig  = 4'hF;
  logic [NCH-1:0] out_sig;
`ifdef DEBOUNCER_EDGE_PULSE_EN
  logic [NCH-1:0] rise_pulse;
  logic [NCH-1:0] fall_pulse;
`endif

  int errors = 0;
  int checks = 0;

  exp_t expQ [$];

  // Reference model state: the raw samples still travelling through the
  // synchroniser, the run of logical samples that currently disagree with
  // the accepted level, and the accepted level itself.
  bit pipeQ [NCH][$];
  bit winQ  [NCH][$];
  bit stM   [NCH];

  logic [NCH-1:0] inReg = 4'hF;

  multi_signal_debouncer #(
    .NUM_CHANNELS   (NCH),
    .DEBOUNCE_COUNT (COUNT),
    .SYNC_STAGES    (SYNC),
    .IN_ACTIVE_LOW  (IN_LOW),
    .OUT_ACTIVE_LOW (OUT_LOW)
  ) dut (
    .sys_clk    (sys_clk),
    .rst        (rst),
    .in_sig     (in_sig),
    .out_sig    (out_sig)
`ifdef DEBOUNCER_EDGE_PULSE_EN
    ,
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse)
`endif
  );

  // 12 MHz system clock.
  always #42 sys_clk = ~sys_clk;

  // One rising edge of the reference model. A new level is accepted once
  // COUNT consecutive synchronised samples disagree with the accepted level.
  task automatic modelStep(input bit r, input logic [NCH-1:0] raw, output exp_t e);
    bit lv;
    e = '0;
    for (int ch = 0; ch < NCH; ch++) begin
      if (r) begin
        pipeQ[ch].delete();
        for (int s = 0; s < SYNC; s++) pipeQ[ch].push_back(IN_LOW[ch]);
        winQ[ch].delete();
        stM[ch] = 1'b0;
      end else begin
        lv = pipeQ[ch][SYNC-1] ^ IN_LOW[ch];
        pipeQ[ch].push_front(raw[ch]);
        void'(pipeQ[ch].pop_back());
        if (lv == stM[ch]) begin
          winQ[ch].delete();
        end else begin
          winQ[ch].push_back(lv);
          if (winQ[ch].size() >= COUNT) begin
            stM[ch] = lv;
            winQ[ch].delete();
            if (lv) e.rise[ch] = 1'b1;
            else    e.fall[ch] = 1'b1;
          end
        end
      end
      e.outv[ch] = stM[ch] ^ OUT_LOW;
    end
  endtask

  // Drive one cycle of stimulus on the falling edge and queue the expected
  // outputs for the rising edge that follows.
  task automatic applyStimulus(input bit r, input logic [NCH-1:0] raw);
    exp_t e;
    @(negedge sys_clk);
    rst    = r;
    in_sig = raw;
    modelStep(r, raw, e);
    expQ.push_back(e);
  endtask

  task automatic runCycles(input int n, input bit r, input logic [NCH-1:0] raw);
    for (int k = 0; k < n; k++) applyStimulus(r, raw);
  endtask

  task automatic checkOutput(input string name, input logic [NCH-1:0] act,
                             input logic [NCH-1:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  // Monitor: every rising edge presents a new output word; compare it with
  // the oldest queued expectation.
  always @(posedge sys_clk) begin
    exp_t e;
    #1;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkOutput("out_sig", out_sig, e.outv);
`ifdef DEBOUNCER_EDGE_PULSE_EN
      checkOutput("rise_pulse", rise_pulse, e.rise);
      checkOutput("fall_pulse", fall_pulse, e.fall);
`endif
    end
  end

  initial begin
    int holdLeft [NCH];
    int rstRoll;

    $display("[TB] start");

    // Reset with inputs idle, then stay idle after release.
    runCycles(4, 1'b1, 4'hF);
    runCycles(10, 1'b0, 4'hF);

    // Clean press on channel 0.
    inReg = 4'hE;
    runCycles(30, 1'b0, inReg);

    // Channel 1 bounces every 5 cycles for 100 cycles, then settles pressed.
    for (int k = 0; k < 100; k++) begin
      if (k % 5 == 0) inReg[1] = ~inReg[1];
      applyStimulus(1'b0, inReg);
    end
    inReg[1] = 1'b0;
    runCycles(30, 1'b0, inReg);

    // Channel 2: 15-cycle glitch rejected, 16-cycle press accepted.
    inReg[2] = 1'b0;
    runCycles(15, 1'b0, inReg);
    inReg[2] = 1'b1;
    runCycles(25, 1'b0, inReg);
    inReg[2] = 1'b0;
    runCycles(16, 1'b0, inReg);
    inReg[2] = 1'b1;
    runCycles(40, 1'b0, inReg);

    // Release channel 1 so the next step lands on 4'b1000.
    inReg[1] = 1'b1;
    runCycles(30, 1'b0, inReg);

    // Channel 0 released and channel 3 pressed on the same edge.
    inReg[0] = 1'b1;
    inReg[3] = 1'b0;
    runCycles(30, 1'b0, inReg);

    // Channel 2 pressed, reset mid-qualification, input kept pressed.
    inReg = 4'hF;
    runCycles(30, 1'b0, inReg);
    inReg[2] = 1'b0;
    runCycles(10, 1'b0, inReg);
    applyStimulus(1'b1, inReg);
    runCycles(30, 1'b0, inReg);

    // Random stimulus: per-channel hold times mixing short bounces with
    // holds long enough to qualify, plus an occasional reset.
    for (int ch = 0; ch < NCH; ch++) holdLeft[ch] = 1;
    for (int k = 0; k < 3000; k++) begin
      for (int ch = 0; ch < NCH; ch++) begin
        holdLeft[ch]--;
        if (holdLeft[ch] <= 0) begin
          inReg[ch] = ~inReg[ch];
          if ($urandom_range(0, 2) == 0) holdLeft[ch] = int'($urandom_range(1, 14));
          else                           holdLeft[ch] = int'($urandom_range(14, 40));
        end
      end
      rstRoll = int'($urandom_range(0, 499));
      applyStimulus(rstRoll == 0, inReg);
    end

    // Let the monitor drain the queue, then confirm nothing was left behind.
    repeat (3) @(posedge sys_clk);
    #2;
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: got %0d pending expected 0", expQ.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
